// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer
// ----------------------------------------------------------------------------
// Program-counter sequencer for the single-cycle MIPS core. Owns the PC
// register plus boot/run/halt/exception control state and picks the next
// fetch address every cycle.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   stall         in   hold PC this cycle (RUN only)
//   branch_taken  in   conditional branch resolved taken
//   branch_imm    in   [15:0] signed branch offset in words
//   jump          in   J/JAL redirect
//   jump_target   in   [25:0] J-format target field
//   jr            in   JR/JALR redirect
//   jr_addr       in   [31:0] register-file target address
//   halt_req      in   enter HALT
//   resume        in   leave HALT
//   exc_req       in   synchronous exception request
//   pc            out  [31:0] current fetch address
//   pc_plus4      out  [31:0] pc + 4 (combinational)
//   epc           out  [31:0] PC of the excepting instruction
//   state         out  [1:0] BOOT=00 RUN=01 HALT=10 EXC=11
//   fetch_valid   out  instruction at pc is to be executed
//   misalign      out  one-cycle pulse on a misaligned JR target
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : JR to a non-word-aligned address raises an exception at
//               exc_req priority and pulses misalign.
//   undefined : JR target low two bits are forced to zero, misalign is 0.
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        halt_req,
    input  logic        resume,
    input  logic        exc_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic [1:0]  state,
    output logic        fetch_valid,
    output logic        misalign
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10,
        EXC  = 2'b11
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_d;
    logic [31:0] epc_d;
    logic        fv_d;
    logic        mis_d;

    logic signed [31:0] br_off;
    logic [31:0]        br_target;
    logic [31:0]        j_target;
    logic [31:0]        jr_target;
    logic               jr_bad;

    assign state    = state_q;
    assign pc_plus4 = pc + 32'd4;

    // Word offset sign-extended to a byte offset; the add wraps silently.
    assign br_off    = $signed({{14{branch_imm[15]}}, branch_imm, 2'b00});
    assign br_target = pc_plus4 + $unsigned(br_off);
    assign j_target  = {pc_plus4[31:28], jump_target, 2'b00};

`ifdef PC_ALIGN_CHECK_EN
    assign jr_bad    = jr && (jr_addr[1:0] != 2'b00);
    assign jr_target = jr_addr;
`else
    assign jr_bad    = 1'b0;
    assign jr_target = jr_addr & 32'hFFFF_FFFC;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        epc_d   = epc;
        mis_d   = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                // A misaligned JR is an exception in its own right, so it
                // outranks halt and stall just like exc_req does.
                if (exc_req || jr_bad) begin
                    state_d = EXC;
                    pc_d    = EXC_VECTOR;
                    epc_d   = pc;
                    mis_d   = jr_bad;
                end else if (halt_req) begin
                    state_d = HALT;
                end else if (stall) begin
                    pc_d = pc;
                end else if (jr) begin
                    pc_d = jr_target;
                end else if (jump) begin
                    pc_d = j_target;
                end else if (branch_taken) begin
                    pc_d = br_target;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            HALT: begin
                // Exception beats resume when both arrive together.
                if (exc_req) begin
                    state_d = EXC;
                    pc_d    = EXC_VECTOR;
                    epc_d   = pc;
                end else if (resume) begin
                    state_d = RUN;
                end
            end
            EXC: state_d = RUN;
            default: state_d = BOOT;
        endcase
        fv_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc          <= RESET_PC;
            epc         <= 32'h0000_0000;
            fetch_valid <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            epc         <= epc_d;
            fetch_valid <= fv_d;
            misalign    <= mis_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer
// Directed bench for pc_sequencer. Each step pushes the expected register
// state into a scoreboard queue when inputs are driven; after the clock edge
// the entry is popped and compared against the DUT outputs.
// ============================================================================
module tb_pc_sequencer;

    localparam logic [1:0] S_BOOT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HALT = 2'b10;
    localparam logic [1:0] S_EXC  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic        halt_req;
    logic        resume;
    logic        exc_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic [1:0]  state;
    logic        fetch_valid;
    logic        misalign;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [1:0]  st;
        logic        fv;
        logic        mis;
        string       tag;
    } exp_t;

    exp_t sb[$];

    int passed = 0;
    int total  = 0;

    pc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_target  (jump_target),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .halt_req     (halt_req),
        .resume       (resume),
        .exc_req      (exc_req),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .epc          (epc),
        .state        (state),
        .fetch_valid  (fetch_valid),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic check_now(input exp_t e);
        chk({e.tag, ".pc"},       pc,                   e.pc);
        chk({e.tag, ".pc_plus4"}, pc_plus4,             e.pc + 32'd4);
        chk({e.tag, ".epc"},      epc,                  e.epc);
        chk({e.tag, ".state"},    {30'd0, state},       {30'd0, e.st});
        chk({e.tag, ".fv"},       {31'd0, fetch_valid}, {31'd0, e.fv});
        chk({e.tag, ".mis"},      {31'd0, misalign},    {31'd0, e.mis});
    endtask

    // Push the expectation for the coming edge, clock once, then pop/compare.
    task automatic step(input logic [31:0] p, input logic [31:0] ep, input logic [1:0] st,
                        input logic fv, input logic mis, input string tag);
        exp_t e;
        exp_t got;
        e.pc = p; e.epc = ep; e.st = st; e.fv = fv; e.mis = mis; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_now(got);
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; branch_imm = 16'h0; jump = 0; jump_target = 26'h0;
        jr = 0; jr_addr = 32'h0; halt_req = 0; resume = 0; exc_req = 0;
    endtask

    initial begin
        exp_t e;
        idle();
        rst_n = 1'b0;
        #3;
        e.pc = 32'h0; e.epc = 32'h0; e.st = S_BOOT; e.fv = 0; e.mis = 0; e.tag = "reset";
        check_now(e);
        rst_n = 1'b1;
        #1;
        e.tag = "boot";
        check_now(e);

        step(32'h0, 32'h0, S_RUN, 1, 0, "boot_to_run");
        step(32'h4, 32'h0, S_RUN, 1, 0, "seq_first");

        // Branch backwards from 0x100.
        jr = 1; jr_addr = 32'h100;
        step(32'h100, 32'h0, S_RUN, 1, 0, "jr_100");
        idle(); branch_taken = 1; branch_imm = 16'hFFFE;
        step(32'h0FC, 32'h0, S_RUN, 1, 0, "branch_back");

        // Jump keeps the upper nibble of pc+4.
        idle(); jr = 1; jr_addr = 32'h1000_0010;
        step(32'h1000_0010, 32'h0, S_RUN, 1, 0, "jr_1000");
        idle(); jump = 1; jump_target = 26'h40;
        step(32'h1000_0100, 32'h0, S_RUN, 1, 0, "jump");

        // Priority among redirects.
        idle(); stall = 1; jr = 1; jr_addr = 32'h200; jump = 1; jump_target = 26'h40;
        branch_taken = 1; branch_imm = 16'h0004;
        step(32'h1000_0100, 32'h0, S_RUN, 1, 0, "stall_wins");
        stall = 0;
        step(32'h200, 32'h0, S_RUN, 1, 0, "jr_wins");
        exc_req = 1;
        step(32'h80, 32'h200, S_EXC, 0, 0, "exc_wins");
        step(32'h80, 32'h200, S_RUN, 1, 0, "exc_ignores_inputs");

        // Halt, hold for five cycles while redirects are ignored, plain resume.
        idle(); jr = 1; jr_addr = 32'h40;
        step(32'h40, 32'h200, S_RUN, 1, 0, "jr_40");
        idle(); halt_req = 1;
        step(32'h40, 32'h200, S_HALT, 0, 0, "halt_enter");
        idle(); jr = 1; jr_addr = 32'h300; jump = 1; branch_taken = 1; stall = 1;
        for (int i = 0; i < 5; i++) step(32'h40, 32'h200, S_HALT, 0, 0, "halt_hold");
        idle(); resume = 1;
        step(32'h40, 32'h200, S_RUN, 1, 0, "resume");
        idle(); halt_req = 1;
        step(32'h40, 32'h200, S_HALT, 0, 0, "halt_again");
        idle(); resume = 1; exc_req = 1;
        step(32'h80, 32'h40, S_EXC, 0, 0, "halt_exc_beats_resume");
        idle();
        step(32'h80, 32'h40, S_RUN, 1, 0, "halt_exc_done");

        // JR alignment handling.
        jr = 1; jr_addr = 32'h300;
        step(32'h300, 32'h40, S_RUN, 1, 0, "jr_300");
        jr_addr = 32'h203;
`ifdef PC_ALIGN_CHECK_EN
        step(32'h80, 32'h300, S_EXC, 0, 1, "jr_misaligned");
        idle();
        step(32'h80, 32'h300, S_RUN, 1, 0, "misalign_clears");
`else
        step(32'h200, 32'h40, S_RUN, 1, 0, "jr_masked");
        idle();
        step(32'h204, 32'h40, S_RUN, 1, 0, "after_jr_masked");
`endif

        // Sequential wrap-around at the top of the address space.
        idle(); jr = 1; jr_addr = 32'hFFFF_FFFC;
`ifdef PC_ALIGN_CHECK_EN
        step(32'hFFFF_FFFC, 32'h300, S_RUN, 1, 0, "jr_top");
        idle();
        step(32'h0, 32'h300, S_RUN, 1, 0, "wrap");
        step(32'h4, 32'h300, S_RUN, 1, 0, "after_wrap");
`else
        step(32'hFFFF_FFFC, 32'h40, S_RUN, 1, 0, "jr_top");
        idle();
        step(32'h0, 32'h40, S_RUN, 1, 0, "wrap");
        step(32'h4, 32'h40, S_RUN, 1, 0, "after_wrap");
`endif

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        e.pc = 32'h0; e.epc = 32'h0; e.st = S_BOOT; e.fv = 0; e.mis = 0; e.tag = "async_reset";
        check_now(e);
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Overall time bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
